// File: rtl/cw_stream_packer.sv
// Buffers message words in a FIFO, serialises them MSB-first and packs
// the bit stream into CW_W-bit codewords, NUM_CW per frame.
module cw_stream_packer #(
    parameter int IN_W   = 8,
    parameter int CW_W   = 13,
    parameter int NUM_CW = 10,
    parameter int DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      start,
    input  logic                      flush,
    input  logic [IN_W-1:0]           din,
    input  logic                      wr_en,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    output logic [CW_W-1:0]           cw_out,
    output logic                      cw_valid,
    input  logic                      cw_ready,
    output logic [$clog2(NUM_CW):0]   cw_idx,
    output logic                      busy,
    output logic                      done
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int IDXW = $clog2(NUM_CW) + 1;
    localparam int BLW  = $clog2(IN_W + 1);
    localparam int BCW  = $clog2(CW_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t          state;
    logic [IN_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count_nxt;
    logic [IN_W-1:0] head;
    logic [IN_W-1:0] word_sr;
    logic [BLW-1:0]  bits_left;
    logic [CW_W-1:0] cw_sr;
    logic [CW_W-1:0] cw_next;
    logic [BCW-1:0]  bitcnt;
    logic            do_flush;
    logic            push;
    logic            pop;
    logic            take;
    logic            bit_avail;
    logic            cur_bit;

    // Handshake between FIFO, serialiser and frame FSM
    always_comb begin
        do_flush  = (state == S_IDLE) && flush;
        push      = wr_en && !full && !do_flush;
        bit_avail = (bits_left != '0) || !empty;
        take      = (state == S_COLLECT) && bit_avail;
        pop       = take && (bits_left == '0);
        head      = mem[rd_ptr];
        cur_bit   = (bits_left != '0) ? word_sr[IN_W-1] : head[IN_W-1];
        cw_next   = {cw_sr[CW_W-2:0], cur_bit};
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = fifo_count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset, the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, registered flags, overflow and bit serialiser
    always_ff @(posedge clk) begin
        if (!rst_b || do_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            overflow   <= 1'b0;
            word_sr    <= '0;
            bits_left  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_nxt;
            full       <= (count_nxt == CNTW'(DEPTH));
            empty      <= (count_nxt == '0);
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                word_sr   <= head << 1;
                bits_left <= BLW'(IN_W - 1);
            end else if (take) begin
                word_sr   <= word_sr << 1;
                bits_left <= bits_left - 1'b1;
            end
        end
    end

    // Frame FSM: collect CW_W bits, present codeword, repeat NUM_CW times
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state    <= S_IDLE;
            cw_sr    <= '0;
            bitcnt   <= '0;
            cw_out   <= '0;
            cw_valid <= 1'b0;
            cw_idx   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        state  <= S_COLLECT;
                        bitcnt <= '0;
                        cw_idx <= '0;
                        busy   <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (take) begin
                        cw_sr <= cw_next;
                        if (bitcnt == BCW'(CW_W - 1)) begin
                            cw_out   <= cw_next;
                            cw_valid <= 1'b1;
                            state    <= S_EMIT;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (cw_ready) begin
                        cw_valid <= 1'b0;
                        if (cw_idx < IDXW'(NUM_CW - 1)) begin
                            cw_idx <= cw_idx + 1'b1;
                            bitcnt <= '0;
                            state  <= S_COLLECT;
                        end else begin
                            cw_idx <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cw_stream_packer.sv
// Bench for cw_stream_packer: bit-stream model feeds a codeword
// scoreboard; table of byte patterns plus multi-cycle corner sequences.
module tb_cw_stream_packer;
    localparam int IN_W   = 8;
    localparam int CW_W   = 13;
    localparam int NUM_CW = 10;
    localparam int DEPTH  = 256;

    logic            clk;
    logic            rst_b;
    logic            start;
    logic            flush;
    logic [7:0]      din;
    logic            wr_en;
    logic            full;
    logic            empty;
    logic [8:0]      fifo_count;
    logic            overflow;
    logic [12:0]     cw_out;
    logic            cw_valid;
    logic            cw_ready;
    logic [4:0]      cw_idx;
    logic            busy;
    logic            done;

    cw_stream_packer #(
        .IN_W(IN_W), .CW_W(CW_W), .NUM_CW(NUM_CW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .flush(flush),
        .din(din), .wr_en(wr_en), .full(full), .empty(empty),
        .fifo_count(fifo_count), .overflow(overflow), .cw_out(cw_out),
        .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_idx(cw_idx),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [7:0]  b;
        logic [12:0] cw0;
        logic [12:0] cw1;
    } vec_t;

    vec_t        tbl [4];
    bit          bitq [$];
    logic [12:0] exp_q [$];
    logic [12:0] got [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          hs_cyc = 0;
    int          done_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] g, logic [31:0] e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, g, e);
        end
    endfunction

    // Codeword monitor: every handshake is compared with the model queue
    always @(negedge clk) begin
        if (rst_b && cw_valid && cw_ready) begin
            got.push_back(cw_out);
            hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cw_extra got=%0h required=none", cw_out);
            end else begin
                chk("cw_scoreboard", 32'(cw_out), 32'(exp_q.pop_front()));
            end
        end
        if (rst_b && done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bitq.push_back(b[i]);
        while (bitq.size() >= CW_W) begin
            logic [12:0] c;
            c = '0;
            for (int j = 0; j < CW_W; j++) c = {c[11:0], bitq.pop_front()};
            exp_q.push_back(c);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        din   = b;
        wr_en = 1'b1;
        model_push(b);
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        bitq.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 3000) begin
            step();
            n++;
        end
        chk(name, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!cw_valid && n < 3000) begin
            step();
            n++;
        end
        chk(name, 32'(cw_valid), 32'd1);
    endtask

    task automatic wait_idx(input int k, input string name);
        int n;
        n = 0;
        while (int'(cw_idx) != k && n < 3000) begin
            step();
            n++;
        end
        chk(name, 32'(cw_idx), 32'(k));
    endtask

    initial begin
        int d0;
        tbl[0] = '{8'hFF, 13'h1FFF, 13'h1FFF};
        tbl[1] = '{8'hA5, 13'h14B4, 13'h1696};
        tbl[2] = '{8'h00, 13'h0000, 13'h0000};
        tbl[3] = '{8'h3C, 13'h0787, 13'h10F0};

        // Reset with random inputs
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start    = 1'($urandom);
            flush    = 1'($urandom);
            wr_en    = 1'($urandom);
            din      = 8'($urandom);
            cw_ready = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk("rst_cw_out", 32'(cw_out), 0);
        chk("rst_cw_valid", 32'(cw_valid), 0);
        chk("rst_cw_idx", 32'(cw_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(fifo_count), 0);
        rst_b = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        wr_en = 1'b0;
        din = '0;
        cw_ready = 1'b1;
        step();

        // Nominal frame
        got.delete();
        for (int i = 1; i <= 17; i++) wr(8'(i));
        chk("nom_count", 32'(fifo_count), 17);
        d0 = done_cnt;
        pulse_start();
        chk("nom_busy", 32'(busy), 1);
        wait_done("nom_done_timeout");
        repeat (5) step();
        chk("nom_ncw", 32'(got.size()), 10);
        chk("nom_cw0", 32'(got[0]), 32'h0020);
        chk("nom_cw1", 32'(got[1]), 32'h080C);
        chk("nom_done_once", 32'(done_cnt - d0), 1);
        chk("nom_done_lat", 32'(done_cyc - hs_cyc), 1);
        chk("nom_count_end", 32'(fifo_count), 0);
        chk("nom_busy_end", 32'(busy), 0);

        // Carry-over plus backpressure on codeword 3
        got.delete();
        for (int i = 8'h20; i <= 8'h2F; i++) wr(8'(i));
        pulse_start();
        wait_idx(3, "bp_idx3_timeout");
        cw_ready = 1'b0;
        wait_valid("bp_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("bp_cw_hold", 32'(cw_out), 32'(exp_q[0]));
            chk("bp_valid_hold", 32'(cw_valid), 1);
            chk("bp_idx_hold", 32'(cw_idx), 3);
            chk("bp_count_hold", 32'(fifo_count), 10);
            step();
        end
        cw_ready = 1'b1;
        step();
        chk("bp_idx4", 32'(cw_idx), 4);
        chk("bp_valid_drop", 32'(cw_valid), 0);
        repeat (12) step();
        chk("bp_lat_early", 32'(cw_valid), 0);
        step();
        chk("bp_lat", 32'(cw_valid), 1);
        wait_done("bp_done_timeout");
        chk("bp_ncw", 32'(got.size()), 10);
        chk("carry_cw0", 32'(got[0]), 32'h0890);

        // Starvation
        do_flush();
        chk("st_empty", 32'(empty), 1);
        got.delete();
        pulse_start();
        repeat (20) step();
        chk("st_valid_low", 32'(cw_valid), 0);
        chk("st_busy", 32'(busy), 1);
        wr(8'hFF);
        repeat (10) step();
        wr(8'hFF);
        wait_valid("st_valid_timeout");
        chk("st_cw0", 32'(cw_out), 32'h1FFF);
        step();
        repeat (20) step();
        chk("st_hold_busy", 32'(busy), 1);
        chk("st_hold_valid", 32'(cw_valid), 0);
        chk("st_hold_idx", 32'(cw_idx), 1);

        // Reset during codeword 5 presentation
        for (int i = 0; i < 10; i++) wr(8'(i * 7 + 3));
        wait_idx(5, "mr_idx5_timeout");
        cw_ready = 1'b0;
        wait_valid("mr_valid_timeout");
        rst_b = 1'b0;
        step();
        chk("mr_valid", 32'(cw_valid), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_empty", 32'(empty), 1);
        chk("mr_count", 32'(fifo_count), 0);
        chk("mr_idx", 32'(cw_idx), 0);
        rst_b = 1'b1;
        bitq.delete();
        exp_q.delete();
        cw_ready = 1'b1;
        step();

        // Table of repeated-byte frames
        for (int t = 0; t < 4; t++) begin
            do_flush();
            got.delete();
            for (int i = 0; i < 17; i++) wr(tbl[t].b);
            pulse_start();
            wait_done("tbl_done_timeout");
            chk("tbl_cw0", 32'(got[0]), 32'(tbl[t].cw0));
            chk("tbl_cw1", 32'(got[1]), 32'(tbl[t].cw1));
        end

        // Overflow and flush
        do_flush();
        for (int i = 0; i < DEPTH; i++) wr(8'(i));
        chk("ov_full", 32'(full), 1);
        chk("ov_count", 32'(fifo_count), 256);
        chk("ov_flag_pre", 32'(overflow), 0);
        din = 8'hAA;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        chk("ov_flag", 32'(overflow), 1);
        chk("ov_count_keep", 32'(fifo_count), 256);
        do_flush();
        chk("fl_count", 32'(fifo_count), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_overflow", 32'(overflow), 0);
        chk("fl_full", 32'(full), 0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
